multi_edge_debouncer: RTL and testbench

Parametrised, multi-channel input conditioner: per channel a synchroniser, a debounce counter, a registered debounced level, and single-cycle rising/falling edge strobes. It sits between raw asynchronous inputs (buttons, switches, external strobes) and the control FSMs. It replaces the single-bit edge detectors wherever inputs are asynchronous or bouncy. All outputs are registered.

---
 rtl/multi_edge_debouncer_debounce_channel.sv | 35 +++
 rtl/multi_edge_debouncer.sv | 33 +++
 tb/tb_multi_edge_debouncer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/multi_edge_debouncer_debounce_channel.sv
// debounce_channel: synchronise, debounce and edge-detect one input; ports clk reset_n tick din -> level p_edge n_edge stb_next
module debounce_channel #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic p_edge,
  output logic n_edge,
  output logic stb_next
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  assign stb_next = (s != level) && tick && (cnt == CNT_W'(DB_CYCLES - 1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      cnt <= (s == level || stb_next) ? '0 : tick ? cnt + 1'b1 : cnt;
      level <= stb_next ? s : level;
      p_edge <= stb_next & s;
      n_edge <= stb_next & ~s;
    end
endmodule

// File: rtl/multi_edge_debouncer.sv
// multi_edge_debouncer: CH debounced inputs with edge strobes; ports clk reset_n tick din -> level p_edge n_edge any_edge
module multi_edge_debouncer #(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] level,
  output logic [CH-1:0] p_edge,
  output logic [CH-1:0] n_edge,
  output logic any_edge
);
  logic [CH-1:0] stb;
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .tick(tick),
      .din(din[i]),
      .level(level[i]),
      .p_edge(p_edge[i]),
      .n_edge(n_edge[i]),
      .stb_next(stb[i])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) any_edge <= 1'b0;
    else any_edge <= |stb;
endmodule

// File: tb/tb_multi_edge_debouncer.sv
// tb_multi_edge_debouncer: random stimulus against a run-length reference model for two configurations
module tb_multi_edge_debouncer;
  logic clk = 0, reset_n = 0, tick = 0;
  logic [3:0] din = '0;
  logic [0:0] din_b = '0;
  logic [3:0] level, p_edge, n_edge;
  logic any_edge;
  logic [0:0] level_b, p_b, n_b;
  logic any_b;
  int errors = 0, checks = 0;

  multi_edge_debouncer dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .din(din),
    .level(level), .p_edge(p_edge), .n_edge(n_edge), .any_edge(any_edge)
  );
  multi_edge_debouncer #(.CH(1), .SYNC_STAGES(2), .DB_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick), .din(din_b),
    .level(level_b), .p_edge(p_b), .n_edge(n_b), .any_edge(any_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: input delayed by two clocks, then count ticks spent away from the accepted level
  bit q[5][$];
  int run[5];
  bit lvl[5], pe[5], ne[5];
  int db[5] = '{16, 16, 16, 16, 1};

  function automatic void model_reset();
    for (int c = 0; c < 5; c++) begin
      q[c] = '{0, 0};
      run[c] = 0;
      lvl[c] = 0;
      pe[c] = 0;
      ne[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < 5; c++) begin
      bit d, s;
      d = (c < 4) ? din[c] : din_b[0];
      s = q[c][0];
      q[c].push_back(d);
      void'(q[c].pop_front());
      pe[c] = 0;
      ne[c] = 0;
      if (s == lvl[c]) run[c] = 0;
      else if (tick) begin
        run[c]++;
        if (run[c] == db[c]) begin
          lvl[c] = s;
          pe[c] = s;
          ne[c] = !s;
          run[c] = 0;
        end
      end
    end
  endfunction

  always @(posedge clk) if (reset_n) model_step();

  task automatic compare();
    logic [3:0] el, ep, en;
    for (int c = 0; c < 4; c++) begin
      el[c] = lvl[c];
      ep[c] = pe[c];
      en[c] = ne[c];
    end
    check("level", level, el);
    check("p_edge", p_edge, ep);
    check("n_edge", n_edge, en);
    check("any_edge", any_edge, |(ep | en));
    check("level_b", level_b, lvl[4]);
    check("p_edge_b", p_b, pe[4]);
    check("n_edge_b", n_b, ne[4]);
    check("any_edge_b", any_b, pe[4] | ne[4]);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    check("rst_level", {level, level_b}, 5'h0);
    check("rst_strobe", {p_edge, n_edge, any_edge, p_b, n_b, any_b}, 12'h0);
    model_reset();
    repeat (2) cyc();
    reset_n = 1;
  endtask

  initial begin
    int first_p, any_cnt, t;
    model_reset();
    din = 4'hF;
    din_b = 1'b1;
    tick = 1;
    repeat (3) cyc();
    reset_n = 1;
    first_p = -1;
    any_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (p_edge == 4'hF && first_p < 0) first_p = k;
      if (any_edge) any_cnt++;
    end
    check("release_latency", first_p, 18);
    check("release_any_pulses", any_cnt, 1);
    check("release_level", level, 4'hF);
    t = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 1500; k++) begin
        t++;
        for (int c = 0; c < 4; c++) if ($urandom_range(9) == 0) din[c] = ~din[c];
        if ($urandom_range(2) == 0) din_b = ~din_b;
        tick = (ph == 0) ? 1'b1 : (ph == 1) ? (t % 4 == 0) : 1'($urandom_range(1));
        if ($urandom_range(399) == 0) do_reset();
        else cyc();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
